// File: rtl/id_issue_ctrl_if.sv
// ID/EX/WB signal bundle for the issue controller.
// master drives decode/EX/WB status, slave answers with issue decisions.
interface id_issue_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             ex_ready;
  logic             ex_redirect;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             issue;
  logic             stall_id;
  logic             flush_id;
  logic [31:0]      pending;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd,
    output ex_ready, ex_redirect, wb_valid, wb_rd,
    input  issue, stall_id, flush_id, pending, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd,
    input  ex_ready, ex_redirect, wb_valid, wb_rd,
    output issue, stall_id, flush_id, pending, stall_cnt
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID->EX issue control: register scoreboard, hazard stall, redirect flush.
// Define ISSUE_STALL_CNT_EN to build the saturating stall-cycle counter.
module id_issue_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic reset,
  id_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  fcnt;
  logic [31:0] pend;
  logic [31:0] pend_nxt;
  logic [31:0] wb_mask;
  logic [31:0] eff;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        wr_op;
  logic        writes_rd;
  logic        hazard;
  logic        in_flush;
  logic        issue;
  logic        stall;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_op    = 1'b0;
    case (bus.id_opcode)
      7'b0110011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr_op    = 1'b1;
      end
      7'b0010011, 7'b0011011,
      7'b1100111, 7'b0000011: begin
        uses_rs1 = 1'b1;
        wr_op    = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        wr_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign writes_rd = wr_op & (bus.id_rd != 5'd0);

  // same-cycle writeback releases the register (write-first regfile)
  assign wb_mask = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
  assign eff     = pend & ~wb_mask;

  assign hazard = (uses_rs1 & eff[bus.id_rs1])
                | (uses_rs2 & eff[bus.id_rs2])
                | (writes_rd & eff[bus.id_rd]);

  assign in_flush = (state == FLUSH);

  assign issue = ~reset & bus.id_valid & bus.ex_ready & ~hazard
               & ~bus.ex_redirect & ~in_flush;
  assign stall = ~reset & bus.id_valid & ~issue & ~in_flush
               & ~bus.ex_redirect;

  assign bus.issue    = issue;
  assign bus.stall_id = stall;
  assign bus.flush_id = ~reset & (bus.ex_redirect | in_flush);
  assign bus.pending  = pend;

  always_comb begin
    pend_nxt = pend;
    if (bus.wb_valid && bus.wb_rd != 5'd0)
      pend_nxt[bus.wb_rd] = 1'b0;
    if (issue && writes_rd)
      pend_nxt[bus.id_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 4'd0;
      pend  <= 32'd0;
    end else begin
      pend <= pend_nxt;
      if (bus.ex_redirect) begin
        state <= FLUSH;
        fcnt  <= FLOAD;
      end else begin
        case (state)
          RUN:   if (stall) state <= STALL;
          STALL: if (issue || !bus.id_valid) state <= RUN;
          FLUSH: begin
            if (fcnt == 4'd0) state <= RUN;
            else              fcnt  <= fcnt - 4'd1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [CNT_W-1:0] scnt;

  always_ff @(posedge clk) begin
    if (reset)
      scnt <= '0;
    else if (stall && scnt != '1)
      scnt <= scnt + 1'b1;
  end

  assign bus.stall_cnt = scnt;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Issue/hazard controller between the instruction decoder (ID) and the execute stage of the single-issue RISC-V pipeline.
- Keeps a 32-entry register scoreboard of in-flight writes and stalls ID on RAW/WAW hazards or when EX is not ready.
- Kills the ID instruction for a programmable number of cycles after a redirect from a taken branch or jump.
- Decides each cycle whether the decoded instruction advances into EX.

Parameters:
- FLUSH_CYCLES, 2, number of cycles ID is killed after a redirect (range 1..15).
- CNT_W, 32, width of the optional stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a decoded instruction.
- id_opcode  input  7  opcode from the decoder.
- id_rs1  input  5  source register 1.
- id_rs2  input  5  source register 2.
- id_rd  input  5  destination register.
- ex_ready  input  1  EX can accept an instruction this cycle.
- ex_redirect  input  1  taken branch/JAL/JALR resolved in EX this cycle.
- wb_valid  input  1  writeback retires a register write this cycle.
- wb_rd  input  5  writeback destination.
- issue  output  1  ID instruction moves to EX this cycle.
- stall_id  output  1  hold PC and the IF/ID register.
- flush_id  output  1  invalidate the IF/ID register.
- pending  output  32  scoreboard; bit r set means a write to xr is in flight.
- stall_cnt  output  CNT_W  stall cycles counted (optional feature).

Behaviour:
- Reset, synchronous: state=RUN, pending=0, flush counter=0, stall_cnt=0. Outputs issue, stall_id and flush_id are 0 while reset is high.
- Use decode from opcode:
  - uses_rs1: 0110011, 0010011, 0011011, 0100011, 1100011, 1100111, 0000011.
  - uses_rs2: 0110011, 0100011, 1100011.
  - writes_rd: 0110011, 0010011, 0011011, 0110111, 0010111, 1101111, 1100111, 0000011, and only when id_rd≠0.
  - Unknown opcodes use nothing and write nothing; they still issue.
- Effective scoreboard: eff = pending & ~(wb_valid ? onehot(wb_rd) : 0). A same-cycle writeback releases the register (register file is write-first).
- hazard = (uses_rs1 & eff[rs1]) | (uses_rs2 & eff[rs2]) | (writes_rd & eff[rd]). x0 never counts as pending.
- issue = id_valid & ex_ready & ~hazard & ~ex_redirect & state≠FLUSH. All of these outputs are combinational.
- stall_id = id_valid & ~issue & state≠FLUSH & ~ex_redirect.
- flush_id = ex_redirect | state==FLUSH.
- States:
  - RUN: moves to STALL when stall_id=1.
  - STALL: returns to RUN when issue=1 or id_valid=0.
  - FLUSH: counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. Returns to RUN on the cycle the counter is 0.
  - From any state, ex_redirect=1 enters FLUSH and reloads the counter. This takes priority over every other transition.
- Scoreboard update each clock:
  - Clear bit wb_rd when wb_valid and wb_rd≠0.
  - Set bit id_rd when issue & writes_rd.
  - If both hit the same bit, set wins.
  - Bit 0 is held at 0.
- A redirect does not modify pending; only younger ID instructions are killed, and those were never issued.
- wb_valid for a register that is not pending is harmless (the bit stays 0).
- The scoreboard is cleared only by reset. Reset mid-FLUSH or mid-STALL returns to RUN with pending=0.

Optional Feature:
- ISSUE_STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every cycle with stall_id=1, saturating at all-ones.
  - It clears on reset.
- ISSUE_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops are inferred.

Test Plan:
- After reset, issue ADDI x5 (0010011, rd=5) with ex_ready=1 → issue=1 that cycle; next cycle pending=0x00000020.
- With pending[5]=1, present ADD x6,x5,x1 → stall_id=1, issue=0. Pulse wb_valid with wb_rd=5 → issue=1 in that same cycle, pending[5]=0 and pending[6]=1 afterwards.
- ex_redirect=1 while id_valid=1, FLUSH_CYCLES=2 → flush_id=1 for 3 consecutive cycles (redirect cycle plus 2 FLUSH cycles), issue=0 throughout, then RUN.
- Any of the following, with pending=0 → always issue, pending stays 0:
  - SW x0,0(x2);
  - BEQ x0,x0 with rd field 0;
  - LUI with rd=x0.
- Hold ex_ready=0 for 4 cycles with ADDI valid → stall_id=1 for 4 cycles, stall_cnt=4 (with ISSUE_STALL_CNT_EN) or 0 (without). Then issue on the first ready cycle.
- Assert reset during STALL with pending=0x000000F0 → next cycle state=RUN, pending=0, stall_cnt=0.
